// File: rtl/vending_txn_ctrl.sv
// Vending transaction controller: coin credit, slot pricing, per-slot stock,
// dispense handshake and one-unit-per-cycle change payout. All outputs are
// registered, so every response shows up the cycle after its input is sampled.
module vending_txn_ctrl #(
    parameter int CREDIT_W   = 8,
    parameter int PRICE0     = 5,
    parameter int PRICE1     = 8,
    parameter int PRICE2     = 10,
    parameter int PRICE3     = 15,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          select,
    input  logic                cancel,
    input  logic                restock,
    input  logic                disp_done,
    output logic                disp_req,
    output logic [1:0]          disp_slot,
    output logic                item_dispense,
    output logic                refund,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                err,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          sold_out,
    output logic                busy
);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t                state, state_nxt;
    logic [CREDIT_W-1:0]   credit_nxt;
    logic [STOCK_W-1:0]    stock [4];
    logic [STOCK_W-1:0]    stock_nxt [4];
    logic [TCNT_W-1:0]     tcnt, tcnt_nxt;
    logic [CREDIT_W:0]     coin_sum;
    logic [CREDIT_W-1:0]   sel_price;
    logic                  pay_out;
    logic                  disp_req_nxt, item_nxt, refund_nxt, pulse_nxt;
    logic                  reject_nxt, err_nxt, busy_nxt;
    logic [1:0]            disp_slot_nxt;
    logic [3:0]            sold_out_nxt;

    function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] v);
        case (v)
            2'b00:   return CREDIT_W'(1);
            2'b01:   return CREDIT_W'(2);
            2'b10:   return CREDIT_W'(5);
            default: return CREDIT_W'(10);
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
        case (s)
            2'b00:   return CREDIT_W'(PRICE0);
            2'b01:   return CREDIT_W'(PRICE1);
            2'b10:   return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    // Next-state, credit/stock update and next output values.
    always_comb begin
        state_nxt     = state;
        credit_nxt    = credit;
        tcnt_nxt      = '0;
        disp_req_nxt  = disp_req;
        disp_slot_nxt = disp_slot;
        item_nxt      = 1'b0;
        pulse_nxt     = 1'b0;
        reject_nxt    = 1'b0;
        err_nxt       = 1'b0;
        pay_out       = 1'b0;
        for (int i = 0; i < 4; i++) stock_nxt[i] = stock[i];
        coin_sum  = {1'b0, credit} + {1'b0, coin_units(coin_val)};
        sel_price = price_of(select);

        case (state)
            IDLE: begin
                if (restock)
                    for (int i = 0; i < 4; i++) stock_nxt[i] = STOCK_W'(STOCK_INIT);
                if (cancel) begin
                    reject_nxt = coin;
                end else if (sel_valid) begin
                    err_nxt    = 1'b1;
                    reject_nxt = coin;
                end else if (coin) begin
                    if (coin_sum[CREDIT_W]) begin
                        reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = CREDIT;
                    end
                end
            end
            CREDIT: begin
                if (cancel) begin
                    reject_nxt = coin;
                    pay_out    = 1'b1;
                end else if (sel_valid) begin
                    reject_nxt = coin;
                    if (stock[select] == '0 || credit < sel_price) begin
                        err_nxt = 1'b1;
                    end else begin
                        credit_nxt        = credit - sel_price;
                        stock_nxt[select] = stock[select] - STOCK_W'(1);
                        disp_slot_nxt     = select;
                        disp_req_nxt      = 1'b1;
                        state_nxt         = DISPENSE;
                    end
                end else if (coin) begin
                    // Overflowing coins are refused outright, never saturated.
                    if (coin_sum[CREDIT_W]) reject_nxt = 1'b1;
                    else                    credit_nxt = coin_sum[CREDIT_W-1:0];
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    pay_out = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end
            DISPENSE: begin
                reject_nxt = coin;
                if (disp_done) begin
                    disp_req_nxt = 1'b0;
                    item_nxt     = 1'b1;
                    pay_out      = 1'b1;
                end
            end
            default: begin
                reject_nxt = coin;
                if (credit == '0) begin
                    state_nxt = IDLE;
                end else begin
                    credit_nxt = credit - CREDIT_W'(1);
                    pulse_nxt  = 1'b1;
                end
            end
        endcase

        // The first change unit goes out on the same edge that enters CHANGE,
        // so refund and change_pulse are high for exactly N cycles.
        if (pay_out) begin
            if (credit != '0) begin
                state_nxt  = CHANGE;
                credit_nxt = credit - CREDIT_W'(1);
                pulse_nxt  = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end

        refund_nxt = (state_nxt == CHANGE);
        busy_nxt   = (state_nxt == CHANGE) || (state_nxt == DISPENSE);
        for (int i = 0; i < 4; i++) sold_out_nxt[i] = (stock_nxt[i] == '0);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            tcnt          <= '0;
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT);
            disp_req      <= 1'b0;
            disp_slot     <= '0;
            item_dispense <= 1'b0;
            refund        <= 1'b0;
            change_pulse  <= 1'b0;
            coin_reject   <= 1'b0;
            err           <= 1'b0;
            sold_out      <= (STOCK_INIT == 0) ? 4'hF : 4'h0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            tcnt          <= tcnt_nxt;
            for (int i = 0; i < 4; i++) stock[i] <= stock_nxt[i];
            disp_req      <= disp_req_nxt;
            disp_slot     <= disp_slot_nxt;
            item_dispense <= item_nxt;
            refund        <= refund_nxt;
            change_pulse  <= pulse_nxt;
            coin_reject   <= reject_nxt;
            err           <= err_nxt;
            sold_out      <= sold_out_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// Bench for vending_txn_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_vending_txn_ctrl;
    localparam int TMO     = 20;
    localparam int MAX_CR  = 255;
    localparam int S_INIT  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin = 1'b0, sel_valid = 1'b0, cancel = 1'b0, restock = 1'b0, disp_done = 1'b0;
    logic [1:0] coin_val = 2'b00, select = 2'b00;
    logic       disp_req, item_dispense, refund, change_pulse, coin_reject, err, busy;
    logic [1:0] disp_slot;
    logic [7:0] credit;
    logic [3:0] sold_out;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int refund_cnt = 0;

    // reference model state
    int  m_credit;
    int  m_stock[4];
    int  m_slot;
    int  m_idle;
    bit  m_motor, m_session, m_paying;
    bit  e_item, e_pulse, e_rej, e_err;
    int  price_tab[4] = '{5, 8, 10, 15};
    int  coin_tab[4]  = '{1, 2, 5, 10};

    vending_txn_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .coin(coin), .coin_val(coin_val),
        .sel_valid(sel_valid), .select(select), .cancel(cancel), .restock(restock),
        .disp_done(disp_done), .disp_req(disp_req), .disp_slot(disp_slot),
        .item_dispense(item_dispense), .refund(refund), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .err(err), .credit(credit), .sold_out(sold_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_payout();
        if (m_credit > 0) begin
            m_paying = 1'b1;
            m_credit--;
            e_pulse  = 1'b1;
        end
    endtask

    // One clock of customer-visible behaviour, from the sampled inputs.
    task automatic model_step();
        e_item = 0; e_pulse = 0; e_rej = 0; e_err = 0;
        if (reset) begin
            m_credit = 0; m_slot = 0; m_idle = 0;
            m_motor = 0; m_session = 0; m_paying = 0;
            foreach (m_stock[i]) m_stock[i] = S_INIT;
        end else if (m_paying) begin
            e_rej = coin;
            if (m_credit == 0) m_paying = 0;
            else begin m_credit--; e_pulse = 1; end
        end else if (m_motor) begin
            e_rej = coin;
            if (disp_done) begin
                m_motor = 0;
                e_item  = 1;
                start_payout();
            end
        end else if (m_session) begin
            if (cancel) begin
                e_rej = coin;
                m_session = 0;
                start_payout();
            end else if (sel_valid) begin
                e_rej  = coin;
                m_idle = 0;
                if (m_stock[select] == 0 || m_credit < price_tab[select]) e_err = 1;
                else begin
                    m_credit -= price_tab[select];
                    m_stock[select]--;
                    m_slot = select;
                    m_motor = 1;
                    m_session = 0;
                end
            end else if (coin) begin
                m_idle = 0;
                if (m_credit + coin_tab[coin_val] > MAX_CR) e_rej = 1;
                else m_credit += coin_tab[coin_val];
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_session = 0;
                    start_payout();
                end
            end
        end else begin
            if (restock) foreach (m_stock[i]) m_stock[i] = S_INIT;
            if (cancel) e_rej = coin;
            else if (sel_valid) begin e_err = 1; e_rej = coin; end
            else if (coin) begin
                m_credit += coin_tab[coin_val];
                m_session = 1;
                m_idle = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_sold;
        for (int i = 0; i < 4; i++) e_sold[i] = (m_stock[i] == 0);
        check({tag, ".credit"},   32'(credit),        32'(m_credit));
        check({tag, ".disp_req"}, 32'(disp_req),      32'(m_motor));
        check({tag, ".slot"},     32'(disp_slot),     32'(m_slot));
        check({tag, ".item"},     32'(item_dispense), 32'(e_item));
        check({tag, ".refund"},   32'(refund),        32'(m_paying));
        check({tag, ".pulse"},    32'(change_pulse),  32'(e_pulse));
        check({tag, ".reject"},   32'(coin_reject),   32'(e_rej));
        check({tag, ".err"},      32'(err),           32'(e_err));
        check({tag, ".sold"},     32'(sold_out),      32'(e_sold));
        check({tag, ".busy"},     32'(busy),          32'(m_paying || m_motor));
    endtask

    task automatic step(input string tag, input bit c, input bit [1:0] cv, input bit s,
                        input bit [1:0] sl, input bit ca, input bit rs, input bit dd, input bit r);
        coin = c; coin_val = cv; sel_valid = s; select = sl;
        cancel = ca; restock = rs; disp_done = dd; reset = r;
        model_step();
        @(posedge clk); #1;
        check_all(tag);
        if (change_pulse) pulse_cnt++;
        if (refund) refund_cnt++;
    endtask

    task automatic tick(input string tag);      step(tag, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic put(input bit [1:0] cv);     step("coin", 1, cv, 0, 0, 0, 0, 0, 0); endtask
    task automatic sel(input bit [1:0] sl);     step("sel", 0, 0, 1, sl, 0, 0, 0, 0); endtask
    task automatic done();                      step("done", 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic drain();
        for (int i = 0; i < 300 && busy; i++) tick("drain");
        check("drain_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        // reset
        step("rst", 0, 0, 0, 0, 0, 0, 0, 1);
        step("rst", 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_credit", 32'(credit), 32'(0));
        check("rst_sold", 32'(sold_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        sel(2'd2);
        check("idle_sel_err", 32'(err), 32'(1));

        // short credit, then a purchase with one unit of change
        put(2'b10); put(2'b01);
        sel(2'd1);
        check("t1_short_err", 32'(err), 32'(1));
        check("t1_short_credit", 32'(credit), 32'(7));
        put(2'b01);
        check("t1_credit9", 32'(credit), 32'(9));
        sel(2'd1);
        check("t1_req", 32'(disp_req), 32'(1));
        check("t1_slot", 32'(disp_slot), 32'(1));
        tick("t1_wait"); tick("t1_wait");
        check("t1_req_held", 32'(disp_req), 32'(1));
        pulse_cnt = 0;
        done();
        check("t1_item", 32'(item_dispense), 32'(1));
        check("t1_refund", 32'(refund), 32'(1));
        tick("t1_end");
        check("t1_pulses", 32'(pulse_cnt), 32'(1));
        check("t1_idle_credit", 32'(credit), 32'(0));
        check("t1_refund_off", 32'(refund), 32'(0));

        // exact payment: no change
        put(2'b10); put(2'b11);
        check("t2_credit15", 32'(credit), 32'(15));
        sel(2'd3);
        pulse_cnt = 0;
        done();
        tick("t2_end");
        check("t2_no_change", 32'(pulse_cnt), 32'(0));
        check("t2_idle", 32'(busy), 32'(0));

        // sell out slot 0
        for (int k = 0; k < 4; k++) begin
            put(2'b10); sel(2'd0); done();
        end
        check("t3_sold0", 32'(sold_out), 32'(4'b0001));
        put(2'b10); sel(2'd0);
        check("t3_soldout_err", 32'(err), 32'(1));
        check("t3_credit5", 32'(credit), 32'(5));
        step("t3_restock_credit", 0, 0, 0, 0, 0, 1, 0, 0);
        check("t3_restock_ignored", 32'(sold_out), 32'(4'b0001));
        pulse_cnt = 0;
        step("t3_cancel", 0, 0, 0, 0, 1, 0, 0, 0);
        drain();
        check("t3_pulses", 32'(pulse_cnt), 32'(5));
        step("restock", 0, 0, 0, 0, 0, 1, 0, 0);
        check("restock_sold", 32'(sold_out), 32'(0));

        // cancel with 12 units, then cancel colliding with a coin
        put(2'b10); put(2'b01); put(2'b10);
        pulse_cnt = 0; refund_cnt = 0;
        step("t4_cancel", 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) tick("t4_pay");
        check("t4_pulses", 32'(pulse_cnt), 32'(12));
        check("t4_refund_cycles", 32'(refund_cnt), 32'(12));
        check("t4_idle", 32'(busy), 32'(0));
        put(2'b10); put(2'b01); put(2'b10);
        pulse_cnt = 0;
        step("t4_cancel_coin", 1, 2'b11, 0, 0, 1, 0, 0, 0);
        check("t4_coin_reject", 32'(coin_reject), 32'(1));
        drain();
        check("t4b_pulses", 32'(pulse_cnt), 32'(12));

        // inactivity timeout
        put(2'b10);
        for (int k = 0; k < TMO - 1; k++) tick("t5_idle");
        check("t5_not_yet", 32'(refund), 32'(0));
        pulse_cnt = 0;
        tick("t5_timeout");
        check("t5_timeout_refund", 32'(refund), 32'(1));
        drain();
        check("t5_pulses", 32'(pulse_cnt), 32'(5));
        put(2'b11); sel(2'd2);
        step("t5_coin_disp", 1, 2'b10, 0, 0, 0, 0, 0, 0);
        check("t5_disp_reject", 32'(coin_reject), 32'(1));
        check("t5_disp_credit", 32'(credit), 32'(0));
        done(); tick("t5_end");

        // overflow refusal, then reset during payout
        for (int k = 0; k < 25; k++) put(2'b11);
        check("t6_credit250", 32'(credit), 32'(250));
        put(2'b11);
        check("t6_overflow_reject", 32'(coin_reject), 32'(1));
        check("t6_overflow_credit", 32'(credit), 32'(250));
        step("t6_cancel", 0, 0, 0, 0, 1, 0, 0, 0);
        tick("t6_pay"); tick("t6_pay");
        step("t6_reset", 0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_reset_credit", 32'(credit), 32'(0));
        check("t6_reset_refund", 32'(refund), 32'(0));
        tick("t6_after");

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            step("rand",
                 ($urandom_range(3) == 0), 2'($urandom_range(3)),
                 ($urandom_range(7) == 0), 2'($urandom_range(3)),
                 ($urandom_range(39) == 0), ($urandom_range(29) == 0),
                 ($urandom_range(2) == 0), ($urandom_range(299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vending_txn_ctrl.md
Name: vending_txn_ctrl

Overview:
- Transaction controller that sequences the vending datapath: accumulates coin credit, looks up slot price, tracks per-slot stock, drives the dispense mechanism with a req/done handshake, and pays out change one unit per cycle.
- Sits between the coin/keypad front-end and the dispense motor driver.
- Provides the item_dispense and refund indications consumed by the vending top level.

Parameters:
- CREDIT_W, 8, credit register width in coin units.
- PRICE0, 5, price of slot 0 in units.
- PRICE1, 8, price of slot 1 in units.
- PRICE2, 10, price of slot 2 in units.
- PRICE3, 15, price of slot 3 in units.
- STOCK_W, 4, per-slot stock counter width.
- STOCK_INIT, 4, stock loaded per slot at reset and on restock.
- TIMEOUT, 1000, idle cycles in CREDIT before auto-refund (must be at least 2).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous active-high reset.
- coin, input, 1, one-cycle pulse: coin inserted.
- coin_val, input, 2, denomination when coin=1: 00=1, 01=2, 10=5, 11=10 units.
- sel_valid, input, 1, one-cycle pulse: selection made.
- select, input, 2, slot index, valid with sel_valid.
- cancel, input, 1, one-cycle pulse: abort and return credit.
- restock, input, 1, pulse; reloads all stock to STOCK_INIT.
- disp_done, input, 1, motor driver completion pulse.
- disp_req, output, 1, dispense request; level, held until disp_done.
- disp_slot, output, 2, slot being dispensed; stable while disp_req=1.
- item_dispense, output, 1, one-cycle pulse: item delivered.
- refund, output, 1, high throughout change payout.
- change_pulse, output, 1, one pulse per unit returned.
- coin_reject, output, 1, one-cycle pulse: coin not accepted.
- err, output, 1, one-cycle pulse: selection refused (sold out or short credit).
- credit, output, CREDIT_W, current credit.
- sold_out, output, 4, bit i = 1 when stock[i] = 0.
- busy, output, 1, state is DISPENSE or CHANGE.

Behaviour:
Reset and clocking:
- clk is the only clock. reset is synchronous and active-high.
- On reset: state=IDLE, credit=0, every stock counter=STOCK_INIT, timeout counter=0.
- All pulse/level outputs are 0 on reset; sold_out reflects stock (0 when STOCK_INIT>0).
- Reset asserted in any state aborts immediately; no change is paid for the aborted credit.
- All outputs are registered. Every response appears the cycle after the triggering input is sampled.

States IDLE, CREDIT, DISPENSE, CHANGE:
- Per-cycle input priority in IDLE/CREDIT: cancel > sel_valid > coin. A lower-priority coin in the same cycle gets coin_reject.
- IDLE: coin adds its value to credit and moves to CREDIT. restock is honoured only in IDLE and ignored elsewhere. sel_valid → err. cancel ignored.
- CREDIT, coin: if credit+val ≤ 2^CREDIT_W−1, add it. Otherwise credit is unchanged and coin_reject pulses (no saturation).
- CREDIT, sel_valid with stock[select]=0 or credit < price[select]: err pulses and the state stays CREDIT.
- CREDIT, sel_valid otherwise: credit −= price, stock[select] −= 1, disp_slot=select, disp_req=1, go to DISPENSE.
- CREDIT, cancel: go to CHANGE.
- CREDIT, timeout: the counter clears on coin, sel_valid or err. Reaching TIMEOUT idle cycles goes to CHANGE.
- DISPENSE: disp_req stays 1 until disp_done is sampled. The next cycle has disp_req=0, item_dispense=1, and goes to CHANGE if credit>0, else IDLE.
- DISPENSE: coins get coin_reject, and cancel/sel_valid are ignored. disp_done outside DISPENSE is ignored.
- CHANGE: refund=1. Each cycle change_pulse=1 and credit −= 1. After the pulse that brings credit to 0, the next cycle has refund=0 and state=IDLE.
- CHANGE: exactly N pulses are issued for credit N. Coins get coin_reject; other inputs are ignored.

Arithmetic:
- Prices are zero-extended to CREDIT_W. Credit never goes negative; the subtract happens only after the compare passes.
- Stock never underflows.

Test Plan:
1. Reset, then coin_val=10 (5) then 01 (2), then sel slot1 (price 8) → err, credit=7. Add 01 → credit 9. sel slot1 → disp_req=1, disp_slot=1. disp_done → item_dispense, then 1 change_pulse with refund=1, then IDLE, credit=0.
2. Exact pay: credit 15, sel slot3 → dispense; after done, straight to IDLE with no change_pulse. stock3=3.
3. Sold out: buy slot0 four times (STOCK_INIT=4) → sold_out[0]=1. A fifth sel slot0 with credit 5 → err, credit stays 5.
4. Cancel with credit 12 → refund high for exactly 12 cycles, 12 change_pulses, then IDLE. Same cycle cancel+coin → coin_reject, 12 pulses.
5. Timeout: TIMEOUT=20, insert 5 and wait idle → CHANGE entered on the 20th idle cycle, 5 pulses. Coin during DISPENSE → coin_reject, credit unchanged.
6. Overflow: credit 250 (CREDIT_W=8), coin 10 → coin_reject, credit 250. Reset mid-CHANGE → credit 0, refund 0 next cycle. restock in IDLE → all stock=4, sold_out=0.
